// File: rtl/linear_layer_pkg.sv
// Shared FSM state encoding and index-width helper for the sequential linear layer.
// No latency or backpressure of its own: types and functions only.
package linear_layer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate; acc is the running sum including the current a*b pair.
// Latency: one cycle per product; clr has priority over en; no backpressure.
module mac_unit #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 34
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc_q;

    assign prod = a * b;
    // Presenting the sum with this cycle's product lets the caller capture a row in the same cycle it clears.
    assign acc  = acc_q + ACC_W'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc;
        end
    end

endmodule

// File: rtl/linear_layer_seq.sv
// Sequential N x N matrix-vector product with constant weights, one MAC per cycle.
// Latency: result valid N*N cycles after acceptance; held in DONE until out_ready, input stalled meanwhile.
module linear_layer_seq
    import linear_layer_pkg::*;
#(
    parameter int                   WIDTH               = 16,
    parameter int                   N                   = 4,
    parameter logic [N*N*WIDTH-1:0] WEIGHTS_MATRIX_FLAT = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in [0:N-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out [0:N-1],
    output logic                    busy
);

    localparam int            IW    = idx_width(N);
    localparam int            ACC_W = 2*WIDTH + IW;
    localparam logic [IW-1:0] LAST  = IW'(N-1);

    state_t                  state, state_nxt;
    logic [IW-1:0]           r_idx, c_idx;
    logic signed [WIDTH-1:0] x_reg [0:N-1];
    logic signed [WIDTH-1:0] w_tbl [0:N-1][0:N-1];
    logic signed [WIDTH-1:0] w_sel, x_sel;
    logic signed [ACC_W-1:0] acc;
    logic                    accept, mac_en, mac_clr, row_end, mat_end;

    // Weight (r,c) sits at the top of the flat vector for (0,0) and walks down.
    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            assign w_tbl[gr][gc] = WEIGHTS_MATRIX_FLAT[(N*N - N*gr - gc)*WIDTH-1 -: WIDTH];
        end
    end

    assign w_sel   = w_tbl[r_idx][c_idx];
    assign x_sel   = x_reg[c_idx];
    assign row_end = (c_idx == LAST);
    assign mat_end = row_end && (r_idx == LAST);
    assign mac_clr = accept || (mac_en && row_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs decode from state alone so neither ready nor valid loops back combinationally.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        mac_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                busy   = 1'b1;
                mac_en = 1'b1;
                if (mat_end) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            c_idx <= '0;
            for (int i = 0; i < N; i++) begin
                x_reg[i] <= '0;
                out[i]   <= '0;
            end
        end else if (accept) begin
            x_reg <= in;
            r_idx <= '0;
            c_idx <= '0;
        end else if (mac_en) begin
            if (row_end) begin
                c_idx      <= '0;
                out[r_idx] <= WIDTH'(acc);
                r_idx      <= mat_end ? '0 : r_idx + 1'b1;
            end else begin
                c_idx <= c_idx + 1'b1;
            end
        end
    end

    mac_unit #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (w_sel),
        .b     (x_sel),
        .acc   (acc)
    );

endmodule

// File: doc/linear_layer_seq.md
LINEAR_LAYER_SEQ -- requirements
Module: linear_layer_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed bit-width of inputs, weights and outputs.
REQ-002 SHALL have parameter N, default 4, input vector length and neuron count (N>=2).
REQ-003 SHALL have parameter WEIGHTS_MATRIX_FLAT, default all zeros, N*N*WIDTH bits; weight (r,c) at bits [(N*N-N*r-c)*WIDTH-1 -: WIDTH].
REQ-004 SHALL have clk  input  1  single clock, all state rising-edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have in_valid  input  1  input vector offered.
REQ-007 SHALL have in_ready  output  1  block accepts input vector.
REQ-008 SHALL have in  input  signed WIDTH x [0:N-1]  input vector.
REQ-009 SHALL have out_valid  output  1  result vector valid.
REQ-010 SHALL have out_ready  input  1  consumer accepts result.
REQ-011 SHALL have out  output  signed WIDTH x [0:N-1]  result vector, out[r] = row r dot in.
REQ-012 SHALL have busy  output  1  high in COMPUTE or DONE.

Function
REQ-013 SHALL implement states IDLE, COMPUTE, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, latch in into internal vector register, clear accumulator, r=0, c=0, go COMPUTE.
REQ-015 COMPUTE: one multiply-accumulate per cycle, acc += W(r,c)*x[c]; c increments 0..N-1, then wraps to 0 with r+1.
REQ-016 When c==N-1, SHALL write final row sum (including this cycle's product) to out[r] and clear acc for next row.
REQ-017 After c==N-1 and r==N-1, SHALL go DONE; COMPUTE lasts exactly N*N cycles.
REQ-018 DONE: out_valid=1, out stable; on out_ready, go IDLE next cycle.
REQ-019 Latency: handshake on edge t -> out_valid high from edge t+N*N onward (first cycle out_valid observable: N*N cycles after acceptance).
REQ-020 in_ready SHALL be 0 in COMPUTE and DONE; in_valid ignored there; in held unsampled.
REQ-021 Product 2*WIDTH bits signed; accumulator 2*WIDTH+clog2(N) bits signed, no overflow inside.
REQ-022 out[r] SHALL be accumulator bits [WIDTH-1:0] (two's-complement wrap, no saturation).
REQ-023 out_valid SHALL not depend combinationally on out_ready; in_ready SHALL not depend combinationally on in_valid.
REQ-024 out SHALL retain last result after DONE->IDLE until overwritten row-by-row in next COMPUTE.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, r=c=0, acc=0, vector register=0, out all 0, out_valid=0, busy=0; in_ready=1 after release.
REQ-026 Reset during COMPUTE or DONE SHALL abandon the operation; no result emitted.

Structure
REQ-027 State enum and index-width helper (clog2 of N) SHALL live in shared package linear_layer_pkg.
REQ-028 Multiply-accumulate SHALL be sub-module mac_unit (signed operands, clear, enable, accumulator output).
REQ-029 Weight selection SHALL be a constant-indexed mux from WEIGHTS_MATRIX_FLAT by (r,c); no weight registers.

Verification (N=4, WIDTH=16)
REQ-030 Identity weights, in={1,2,3,4} accepted -> out={1,2,3,4}, out_valid 16 cycles after acceptance.
REQ-031 Row 0 all -1 (0xFFFF), others 0, in={-1,-2,3,4} -> out[0]=0xFFFC, out[1..3]=0.
REQ-032 All weights 0x7FFF, in all 0x7FFF -> every out[r]=0x0004 (wrap per REQ-022).
REQ-033 out_ready low 5 cycles in DONE -> out_valid and out held stable; in_valid pulses ignored, in_ready=0; accepted on 6th cycle, IDLE next.
REQ-034 rst_n asserted at COMPUTE cycle 7 -> out all 0, out_valid=0, in_ready=1 after release; next vector computes correctly.
REQ-035 Back-to-back vectors with in_valid held high -> second accepted the cycle after DONE->IDLE, results correct per vector.
